// File: rtl/imm_enc.sv
`timescale 1ns/1ps
// RV64 instruction encoder with li expansion and a registered valid/ready output stage.
// Define IMM_ENC_RANGE_CHECK_EN to turn immediate range/alignment violations into error beats.
module imm_enc (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic        i_Valid,
   output logic        o_Ready,
   input  logic [2:0]  i_Format,
   input  logic [6:0]  i_Opcode,
   input  logic [2:0]  i_Funct3,
   input  logic [6:0]  i_Funct7,
   input  logic [4:0]  i_Rd,
   input  logic [4:0]  i_Rs1,
   input  logic [4:0]  i_Rs2,
   input  logic [63:0] i_Immediate,
   output logic        o_Valid,
   input  logic        i_Ready,
   output logic [31:0] o_Instr,
   output logic        o_Error
);

   // state    | meaning
   // S_IDLE   | output register empty
   // S_OUT    | one beat held
   // S_OUT2   | li LUI beat held, ADDIW beat pending in second_q
   typedef enum logic [1:0] {S_IDLE, S_OUT, S_OUT2} state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state, state_nxt;
   logic [31:0] instr_nxt, second_q, second_nxt;
   logic        err_nxt;
   logic        accept;

   logic [31:0] enc_instr, enc_second;
   logic        enc_err, enc_two;
   logic        range_ok;
   logic [63:0] li_val;
   logic        li_fits12, li_fits32;
   logic [19:0] li_hi;

`ifdef IMM_ENC_RANGE_CHECK_EN
   logic fits12, fits13, fits21, fits32;

   assign li_val = i_Immediate;
   assign fits12 = (&i_Immediate[63:11]) | ~(|i_Immediate[63:11]);
   assign fits13 = (&i_Immediate[63:12]) | ~(|i_Immediate[63:12]);
   assign fits21 = (&i_Immediate[63:20]) | ~(|i_Immediate[63:20]);
   assign fits32 = (&i_Immediate[63:31]) | ~(|i_Immediate[63:31]);

   always_comb begin
      range_ok = 1'b1;
      case (i_Format)
         3'd1, 3'd2: range_ok = fits12;
         3'd3:       range_ok = fits13 & ~i_Immediate[0];
         3'd4:       range_ok = fits32 & ~(|i_Immediate[11:0]);
         3'd5:       range_ok = fits21 & ~i_Immediate[0];
         3'd6:       range_ok = li_fits32;
         default:    range_ok = 1'b1;
      endcase
   end
`else
   logic unused_imm_hi;

   // Unchecked li works from the low word, so it always fits 32 bits.
   assign li_val        = {{32{i_Immediate[31]}}, i_Immediate[31:0]};
   assign range_ok      = 1'b1;
   assign unused_imm_hi = ^i_Immediate[63:32];
`endif

   assign li_fits12  = (&li_val[63:11]) | ~(|li_val[63:11]);
   assign li_fits32  = (&li_val[63:31]) | ~(|li_val[63:31]);
   // (imm + 0x800)[31:12]: the rounding carry enters bit 12 exactly when bit 11 is set.
   assign li_hi      = li_val[31:12] + {19'd0, li_val[11]};
   assign enc_second = {li_val[11:0], i_Rd, 3'b000, i_Rd, 7'h1B};

   always_comb begin
      enc_instr = NOP;
      enc_err   = 1'b0;
      enc_two   = 1'b0;
      case (i_Format)
         3'd0: enc_instr = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_Opcode};
         3'd1: enc_instr = {i_Immediate[11:0], i_Rs1, i_Funct3, i_Rd, i_Opcode};
         3'd2: enc_instr = {i_Immediate[11:5], i_Rs2, i_Rs1, i_Funct3,
                            i_Immediate[4:0], i_Opcode};
         3'd3: enc_instr = {i_Immediate[12], i_Immediate[10:5], i_Rs2, i_Rs1, i_Funct3,
                            i_Immediate[4:1], i_Immediate[11], i_Opcode};
         3'd4: enc_instr = {i_Immediate[31:12], i_Rd, i_Opcode};
         3'd5: enc_instr = {i_Immediate[20], i_Immediate[10:1], i_Immediate[11],
                            i_Immediate[19:12], i_Rd, i_Opcode};
         3'd6: begin
            if (li_fits12) begin
               enc_instr = {li_val[11:0], 5'd0, 3'b000, i_Rd, 7'h13};
            end else begin
               enc_instr = {li_hi, i_Rd, 7'h37};
               enc_two   = |li_val[11:0];
            end
         end
         default: enc_err = 1'b1;
      endcase
      if (!range_ok) begin
         enc_instr = NOP;
         enc_err   = 1'b1;
         enc_two   = 1'b0;
      end
   end

   assign o_Valid = (state != S_IDLE);
   assign o_Ready = i_Rst_n && (state != S_OUT2) && (!o_Valid || i_Ready);
   assign accept  = i_Valid && o_Ready;

   always_comb begin
      state_nxt  = state;
      instr_nxt  = o_Instr;
      err_nxt    = o_Error;
      second_nxt = second_q;
      case (state)
         S_IDLE, S_OUT: begin
            if (accept) begin
               instr_nxt  = enc_instr;
               err_nxt    = enc_err;
               second_nxt = enc_second;
               state_nxt  = enc_two ? S_OUT2 : S_OUT;
            end else if (state == S_OUT && i_Ready) begin
               state_nxt = S_IDLE;
            end
         end
         S_OUT2: begin
            if (i_Ready) begin
               instr_nxt = second_q;
               err_nxt   = 1'b0;
               state_nxt = S_OUT;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state    <= S_IDLE;
         o_Instr  <= 32'd0;
         o_Error  <= 1'b0;
         second_q <= 32'd0;
      end else begin
         state    <= state_nxt;
         o_Instr  <= instr_nxt;
         o_Error  <= err_nxt;
         second_q <= second_nxt;
      end
   end

endmodule

// File: tb/tb_imm_enc.sv
`timescale 1ns/1ps
// Directed-vector bench for imm_enc: encodings, li expansion, backpressure and reset.
module tb_imm_enc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [63:0] imm;
   logic        out_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_enc dut (
      .i_Clk       (clk),
      .i_Rst_n     (rst_n),
      .i_Valid     (in_valid),
      .o_Ready     (out_ready),
      .i_Format    (fmt),
      .i_Opcode    (opcode),
      .i_Funct3    (funct3),
      .i_Funct7    (funct7),
      .i_Rd        (rd),
      .i_Rs1       (rs1),
      .i_Rs2       (rs2),
      .i_Immediate (imm),
      .o_Valid     (out_valid),
      .i_Ready     (in_ready),
      .o_Instr     (instr),
      .o_Error     (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [63:0] im);
      fmt = f; opcode = op; funct3 = f3; funct7 = f7;
      rd = d; rs1 = s1; rs2 = s2; imm = im;
      in_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_ready = 1'b1;
      set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", err); end
      checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", out_ready); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", out_ready); end
   endtask

   task automatic test_i_type();
      set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL itype_valid got=%b exp=1", out_valid); end
      checks++; if (instr !== 32'hFFF0_0093) begin failures++; $display("FAIL itype_instr got=%h exp=fff00093", instr); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL itype_error got=%b exp=0", err); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL itype_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_b_type();
      set_req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8);
      tick();
      in_valid = 1'b0;
      checks++; if (instr !== 32'h0020_8463 || err !== 1'b0) begin failures++; $display("FAIL btype_instr got=%h/%b exp=00208463/0", instr, err); end
      tick();
      set_req(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd9);
      tick();
      in_valid = 1'b0;
`ifdef IMM_ENC_RANGE_CHECK_EN
      checks++; if (instr !== 32'h0000_0013 || err !== 1'b1) begin failures++; $display("FAIL btype_misaligned got=%h/%b exp=00000013/1", instr, err); end
`else
      checks++; if (instr !== 32'h0020_8463 || err !== 1'b0) begin failures++; $display("FAIL btype_misaligned got=%h/%b exp=00208463/0", instr, err); end
`endif
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL btype_valid got=%b exp=1", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL btype_one_beat got=%b exp=0", out_valid); end
   endtask

   task automatic test_li();
      set_req(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5678);
      tick();
      in_valid = 1'b0;
      checks++; if (instr !== 32'h1234_52B7 || out_valid !== 1'b1) begin failures++; $display("FAIL li_lui got=%h/%b exp=123452b7/1", instr, out_valid); end
      checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL li_ready_between got=%b exp=0", out_ready); end
      tick();
      checks++; if (instr !== 32'h6782_829B || err !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL li_addiw got=%h/%b/%b exp=6782829b/0/1", instr, err, out_valid); end
      checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL li_ready_after got=%b exp=1", out_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL li_two_beats_only got=%b exp=0", out_valid); end

      set_req(3'd6, 7'h7F, 3'd7, 7'h7F, 5'd5, 5'd31, 5'd31, 64'h1000);
      tick();
      in_valid = 1'b0;
      checks++; if (instr !== 32'h0000_12B7 || out_valid !== 1'b1) begin failures++; $display("FAIL li_lui_only got=%h/%b exp=000012b7/1", instr, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL li_lui_single got=%b exp=0", out_valid); end

      set_req(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      in_valid = 1'b0;
      checks++; if (instr !== 32'hFFF0_0293 || err !== 1'b0) begin failures++; $display("FAIL li_addi got=%h/%b exp=fff00293/0", instr, err); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL li_addi_single got=%b exp=0", out_valid); end

      set_req(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1_0000_0000);
      tick();
      in_valid = 1'b0;
`ifdef IMM_ENC_RANGE_CHECK_EN
      checks++; if (instr !== 32'h0000_0013 || err !== 1'b1) begin failures++; $display("FAIL li_too_wide got=%h/%b exp=00000013/1", instr, err); end
`else
      checks++; if (instr !== 32'h0000_0293 || err !== 1'b0) begin failures++; $display("FAIL li_too_wide got=%h/%b exp=00000293/0", instr, err); end
`endif
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL li_too_wide_single got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      in_ready = 1'b0;
      set_req(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5678);
      tick();
      set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         checks++; if (instr !== 32'h1234_52B7 || out_valid !== 1'b1 || out_ready !== 1'b0) begin
            failures++; $display("FAIL stall_hold cycle=%0d got=%h/%b/%b exp=123452b7/1/0", i, instr, out_valid, out_ready);
         end
         tick();
      end
      in_ready = 1'b1;
      #1;
      checks++; if (out_ready !== 1'b0) begin failures++; $display("FAIL stall_release_ready got=%b exp=0", out_ready); end
      tick();
      checks++; if (instr !== 32'h6782_829B || out_valid !== 1'b1) begin failures++; $display("FAIL drain_addiw got=%h/%b exp=6782829b/1", instr, out_valid); end
      checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%b exp=1", out_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (instr !== 32'hFFF0_0093 || out_valid !== 1'b1) begin failures++; $display("FAIL drain_next got=%h/%b exp=fff00093/1", instr, out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  t_fmt [5];
      logic [6:0]  t_op  [5];
      logic [2:0]  t_f3  [5];
      logic [6:0]  t_f7  [5];
      logic [4:0]  t_rd  [5];
      logic [4:0]  t_rs1 [5];
      logic [4:0]  t_rs2 [5];
      logic [63:0] t_imm [5];
      logic [31:0] t_exp [5];
      logic        t_err [5];
      // sub x3,x1,x2
      t_fmt[0] = 3'd0; t_op[0] = 7'h33; t_f3[0] = 3'd0; t_f7[0] = 7'h20; t_rd[0] = 5'd3; t_rs1[0] = 5'd1; t_rs2[0] = 5'd2;
      t_imm[0] = 64'h0; t_exp[0] = 32'h4020_81B3; t_err[0] = 1'b0;
      // sd x10,-8(x2)
      t_fmt[1] = 3'd2; t_op[1] = 7'h23; t_f3[1] = 3'd3; t_f7[1] = 7'h00; t_rd[1] = 5'd0; t_rs1[1] = 5'd2; t_rs2[1] = 5'd10;
      t_imm[1] = 64'hFFFF_FFFF_FFFF_FFF8; t_exp[1] = 32'hFEA1_3C23; t_err[1] = 1'b0;
      // lui x3,0xabcde
      t_fmt[2] = 3'd4; t_op[2] = 7'h37; t_f3[2] = 3'd0; t_f7[2] = 7'h00; t_rd[2] = 5'd3; t_rs1[2] = 5'd0; t_rs2[2] = 5'd0;
      t_imm[2] = 64'hFFFF_FFFF_ABCD_E000; t_exp[2] = 32'hABCD_E1B7; t_err[2] = 1'b0;
      // jal x1,+0x12344
      t_fmt[3] = 3'd5; t_op[3] = 7'h6F; t_f3[3] = 3'd0; t_f7[3] = 7'h00; t_rd[3] = 5'd1; t_rs1[3] = 5'd0; t_rs2[3] = 5'd0;
      t_imm[3] = 64'h1_2344; t_exp[3] = 32'h3441_20EF; t_err[3] = 1'b0;
      // reserved format
      t_fmt[4] = 3'd7; t_op[4] = 7'h33; t_f3[4] = 3'd0; t_f7[4] = 7'h00; t_rd[4] = 5'd3; t_rs1[4] = 5'd1; t_rs2[4] = 5'd2;
      t_imm[4] = 64'h0; t_exp[4] = 32'h0000_0013; t_err[4] = 1'b1;
      in_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_req(t_fmt[i], t_op[i], t_f3[i], t_f7[i], t_rd[i], t_rs1[i], t_rs2[i], t_imm[i]);
         #1;
         checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, out_ready); end
         tick();
         checks++; if (instr !== t_exp[i] || err !== t_err[i] || out_valid !== 1'b1) begin
            failures++; $display("FAIL b2b_beat idx=%0d got=%h/%b/%b exp=%h/%b/1", i, instr, err, out_valid, t_exp[i], t_err[i]);
         end
      end
      in_valid = 1'b0;
      in_ready = 1'b0;
      tick();
      checks++; if (instr !== 32'h0000_0013 || err !== 1'b1 || out_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%h/%b/%b exp=00000013/1/0", instr, err, out_ready); end
      in_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid_li();
      in_ready = 1'b1;
      set_req(3'd6, 7'h00, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5678);
      tick();
      in_valid = 1'b0;
      checks++; if (instr !== 32'h1234_52B7) begin failures++; $display("FAIL rstli_lui got=%h exp=123452b7", instr); end
      rst_n = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || out_ready !== 1'b0) begin failures++; $display("FAIL rstli_cleared got=%b/%b exp=0/0", out_valid, out_ready); end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstli_no_addiw cycle=%0d got=%b/%h exp=0", i, out_valid, instr); end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b1;
      fmt = 3'd0; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 64'd0;
      test_reset();
      test_i_type();
      test_b_type();
      test_li();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_li();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
